// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-flop synchronizer, debounce FSM and
// press / release / auto-repeat pulse generation. Raw buttons are active-low;
// every output is active-high.
module button_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned CNT_WIDTH       = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned REPEAT_ENABLE   = 1
) (
  input  logic                   in_clk,
  input  logic                   global_reset,
  input  logic [NUM_BUTTONS-1:0] in_button,
  output logic [NUM_BUTTONS-1:0] out_level,
  output logic [NUM_BUTTONS-1:0] out_press,
  output logic [NUM_BUTTONS-1:0] out_release,
  output logic [NUM_BUTTONS-1:0] out_repeat,
  output logic [NUM_BUTTONS-1:0] out_step
);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  localparam logic [CNT_WIDTH-1:0] DebLast    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DelayLast  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PeriodLast = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] repeat_q, repeat_d;
  // Set once the first (long-delay) repeat of the current hold has fired.
  logic [NUM_BUTTONS-1:0] rep_done_q, rep_done_d;

  logic [NUM_BUTTONS-1:0][1:0]           state_q, state_d;
  logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0][CNT_WIDTH-1:0] rcnt_q, rcnt_d;

  // Next-state logic: synchronizer shift plus independent per-channel FSMs.
  always_comb begin
    sync1_d    = in_button;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    rep_done_d = rep_done_q;
    level_d    = level_q;
    press_d    = '0;
    release_d  = '0;
    repeat_d   = '0;

    for (int i = 0; i < NUM_BUTTONS; i++) begin
      // sync2_q is still active-low here: 0 means pressed.
      case (state_q[i])
        StIdle: begin
          if (!sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i]    = StHeld;
            press_d[i]    = 1'b1;
            level_d[i]    = 1'b1;
            rcnt_d[i]     = '0;
            rep_done_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StHeld: begin
          if (sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end else if (REPEAT_ENABLE != 0) begin
            if (!rep_done_q[i]) begin
              if (rcnt_q[i] == DelayLast) begin
                repeat_d[i]   = 1'b1;
                rep_done_d[i] = 1'b1;
                rcnt_d[i]     = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + CntOne;
              end
            end else if (rcnt_q[i] == PeriodLast) begin
              repeat_d[i] = 1'b1;
              rcnt_d[i]   = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + CntOne;
            end
          end
        end
        StReleaseWait: begin
          if (!sync2_q[i]) begin
            // Release was a bounce: the repeat delay phase starts over.
            state_d[i]    = StHeld;
            rcnt_d[i]     = '0;
            rep_done_d[i] = 1'b0;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i]   = StIdle;
            release_d[i] = 1'b1;
            level_d[i]   = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // State registers; synchronous reset wins over everything and emits no pulses.
  always_ff @(posedge in_clk) begin
    if (global_reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= {NUM_BUTTONS{StIdle}};
      cnt_q      <= '0;
      rcnt_q     <= '0;
      rep_done_q <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      rep_done_q <= rep_done_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
    end
  end

  assign out_level   = level_q;
  assign out_press   = press_q;
  assign out_release = release_q;
  assign out_repeat  = repeat_q;
  assign out_step    = press_q | repeat_q;

endmodule
